// File: rtl/delay_arbiter_if.sv
// delay_arbiter_if: bundles the client side (req/n_bus/grant/done/busy) and the
// timer side (trig_out/n_out/time_out_in) of the shared delay-timer arbiter.
interface delay_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int BIT_SZ = 10
);
    logic [NREQ-1:0]        req;
    logic [NREQ*BIT_SZ-1:0] n_bus;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic                   trig_out;
    logic [BIT_SZ-1:0]      n_out;
    logic                   time_out_in;

    // Environment side: clients plus the timer's time_out output.
    modport master (
        output req, n_bus, time_out_in,
        input  grant, done, busy, trig_out, n_out
    );

    // Arbiter side.
    modport slave (
        input  req, n_bus, time_out_in,
        output grant, done, busy, trig_out, n_out
    );
endinterface

// File: rtl/delay_arbiter.sv
// delay_arbiter: gives NREQ clients exclusive use of one delay timer.
// A winner is latched with its delay, the timer is triggered (unless the delay
// is zero), the arbiter waits for time_out to rise and then fall again, and
// finally pulses done on the winner's bit.
// Build option: define DELAY_ARB_RR_EN for round-robin selection; otherwise the
// lowest requesting index wins (fixed priority, no pointer state).
module delay_arbiter #(
    parameter int NREQ   = 4,
    parameter int BIT_SZ = 10
) (
    input  logic           sysclk,
    input  logic           reset,
    delay_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RELEASE, DONE} state_t;

    state_t            state;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;
    logic              trig_q;
    logic [BIT_SZ-1:0] n_q;

    logic [PW-1:0]     win;
    logic [BIT_SZ-1:0] n_sel;

`ifdef DELAY_ARB_RR_EN
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win_q;

    // Round-robin pick: scanning downward lets the nearest index at/after ptr win.
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr) + k) % NREQ])
                win = PW'((int'(ptr) + k) % NREQ);
        end
    end
`else
    // Fixed priority: lowest set index wins.
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k])
                win = PW'(k);
        end
    end
`endif

    assign n_sel = bus.n_bus[win*BIT_SZ +: BIT_SZ];

    // Service FSM; every output is a register so the timer and clients see clean levels.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            trig_q  <= 1'b0;
            n_q     <= '0;
`ifdef DELAY_ARB_RR_EN
            ptr     <= '0;
            win_q   <= '0;
`endif
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    // The timer has no reset, so never start while it still reports time_out.
                    if ((|bus.req) && !bus.time_out_in) begin
                        grant_q <= NREQ'(1) << win;
                        busy_q  <= 1'b1;
                        n_q     <= n_sel;
`ifdef DELAY_ARB_RR_EN
                        win_q   <= win;
`endif
                        if (n_sel != '0) begin
                            trig_q <= 1'b1;
                            state  <= ARM;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
                ARM: begin
                    if (bus.time_out_in) begin
                        trig_q <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the timer to drop back to idle before releasing the client.
                    if (!bus.time_out_in)
                        state <= DONE;
                end
                DONE: begin
                    done_q  <= grant_q;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
`ifdef DELAY_ARB_RR_EN
                    ptr     <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.trig_out = trig_q;
    assign bus.n_out    = n_q;
endmodule
